// File: rtl/sha1_pkg.sv
// Shared widths, block layout, pad constants and feeder state encoding
// for the SHA1 block feeder.
package sha1_pkg;

    localparam int unsigned BLOCK_W     = 512;
    localparam int unsigned DIGEST_W    = 160;
    localparam int unsigned BLOCK_BYTES = BLOCK_W / 8;
    localparam int unsigned LEN_OFFSET  = 56;
    localparam logic [7:0]  PAD_BYTE    = 8'h80;

    // Index BLOCK_BYTES-1 is message byte 0, so the packed vector is big-endian.
    typedef logic [BLOCK_BYTES-1:0][7:0] block_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_FILL,
        S_PAD,
        S_FEED,
        S_WAIT,
        S_EXTRA,
        S_OUT
    } feeder_state_e;

endpackage

// File: rtl/sha1_block_feeder_if.sv
// Byte-stream valid/ready channel from the message builder into the feeder.
interface sha1_block_feeder_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/sha1_pad_block.sv
// Combinational padder: builds either the final data block (0x80 at byte k,
// zero fill, optional length) or the padding-only extra block.
module sha1_pad_block
    import sha1_pkg::*;
(
    input  block_t      block,
    input  logic [5:0]  k,
    input  logic        extra,
    input  logic [63:0] bit_len,
    output block_t      padded
);

    always_comb begin
        padded = '0;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (extra) begin
                if (i == 0 && k == 6'd0) begin
                    padded[BLOCK_BYTES-1] = PAD_BYTE;
                end
            end else if (k == 6'd0 || 6'(i) < k) begin
                padded[BLOCK_BYTES-1-i] = block[BLOCK_BYTES-1-i];
            end else if (6'(i) == k) begin
                padded[BLOCK_BYTES-1-i] = PAD_BYTE;
            end
        end
        // Length lands in bytes 56..63 only when it fits behind the 0x80 marker.
        if (extra || (k != 6'd0 && k < 6'(LEN_OFFSET))) begin
            padded[7:0] = bit_len;
        end
    end

endmodule

// File: rtl/sha1_block_feeder.sv
// Assembles a byte stream into padded 512-bit SHA1 blocks, hands them to the
// compression core one at a time and publishes the digest per message.
module sha1_block_feeder
    import sha1_pkg::*;
#(
    parameter int unsigned LEN_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    sha1_block_feeder_if.slave  in_if,
    output logic                core_init,
    output logic                core_feed,
    output block_t              core_message,
    input  logic                core_done,
    input  logic [DIGEST_W-1:0] core_hash,
    output logic [DIGEST_W-1:0] hash,
    output logic                hash_valid,
    output logic                busy
);

    feeder_state_e       state, state_n;
    logic [LEN_W-1:0]    count, count_n;
    block_t              blk_n, padded_c;
    logic                last_q, last_n;
    logic                more_q, more_n;
    logic                extra_q, extra_n;
    logic                seen_low_q, seen_low_n;
    logic                in_ready_n, core_init_n, core_feed_n;
    logic [DIGEST_W-1:0] hash_n;
    logic                hash_valid_n, busy_n;
    logic                accept_c, extra_sel_c;
    logic [5:0]          offset_c;
    logic [63:0]         bit_len_c;

    assign accept_c    = in_if.in_valid && in_if.in_ready;
    assign offset_c    = count[5:0];
    assign bit_len_c   = 64'(count) << 3;
    assign extra_sel_c = (state == S_EXTRA);

    sha1_pad_block u_pad (
        .block   (core_message),
        .k       (offset_c),
        .extra   (extra_sel_c),
        .bit_len (bit_len_c),
        .padded  (padded_c)
    );

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            count          <= '0;
            core_message   <= '0;
            last_q         <= 1'b0;
            more_q         <= 1'b0;
            extra_q        <= 1'b0;
            seen_low_q     <= 1'b0;
            in_if.in_ready <= 1'b0;
            core_init      <= 1'b0;
            core_feed      <= 1'b0;
            hash           <= '0;
            hash_valid     <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_n;
            count          <= count_n;
            core_message   <= blk_n;
            last_q         <= last_n;
            more_q         <= more_n;
            extra_q        <= extra_n;
            seen_low_q     <= seen_low_n;
            in_if.in_ready <= in_ready_n;
            core_init      <= core_init_n;
            core_feed      <= core_feed_n;
            hash           <= hash_n;
            hash_valid     <= hash_valid_n;
            busy           <= busy_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n      = state;
        count_n      = count;
        blk_n        = core_message;
        last_n       = last_q;
        more_n       = more_q;
        extra_n      = extra_q;
        seen_low_n   = seen_low_q;
        core_init_n  = 1'b0;
        hash_n       = hash;
        hash_valid_n = 1'b0;
        busy_n       = busy;

        case (state)
            S_IDLE: begin
                if (accept_c) begin
                    blk_n                = '0;
                    blk_n[BLOCK_BYTES-1] = in_if.in_data;
                    count_n              = LEN_W'(1);
                    last_n               = in_if.in_last;
                    more_n               = 1'b0;
                    extra_n              = 1'b0;
                    core_init_n          = 1'b1;
                    busy_n               = 1'b1;
                    state_n              = S_INIT;
                end
            end
            S_INIT: state_n = last_q ? S_PAD : S_FILL;
            S_FILL: begin
                if (accept_c) begin
                    blk_n[6'd63 - offset_c] = in_if.in_data;
                    count_n                 = count + LEN_W'(1);
                    if (in_if.in_last) begin
                        state_n = S_PAD;
                    end else if (offset_c == 6'd63) begin
                        more_n  = 1'b1;
                        state_n = S_FEED;
                    end
                end
            end
            S_PAD: begin
                // A full block or one with no room for the length needs a trailing pad block.
                blk_n   = padded_c;
                extra_n = (offset_c == 6'd0) || (offset_c >= 6'(LEN_OFFSET));
                state_n = S_FEED;
            end
            S_FEED: begin
                seen_low_n = 1'b0;
                if (core_done && core_feed) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!core_done) begin
                    seen_low_n = 1'b1;
                end else if (seen_low_q) begin
                    if (more_q) begin
                        blk_n   = '0;
                        more_n  = 1'b0;
                        state_n = S_FILL;
                    end else if (extra_q) begin
                        state_n = S_EXTRA;
                    end else begin
                        state_n = S_OUT;
                    end
                end
            end
            S_EXTRA: begin
                blk_n   = padded_c;
                extra_n = 1'b0;
                state_n = S_FEED;
            end
            S_OUT: begin
                hash_n       = core_hash;
                hash_valid_n = 1'b1;
                busy_n       = 1'b0;
                state_n      = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        in_ready_n  = (state_n == S_IDLE) || (state_n == S_FILL);
        core_feed_n = (state_n == S_FEED);
    end

endmodule

// File: tb/tb_sha1_block_feeder.sv
// Scoreboard bench for sha1_block_feeder with a behavioural SHA1 core and
// an RFC-3174 reference padder/hasher.
module tb_sha1_block_feeder;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        string        name;
        logic [511:0] act;
        logic [511:0] exp;
    } chk_t;

    localparam logic [159:0] H0 = 160'h67452301efcdab8998badcfe10325476c3d2e1f0;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         core_init, core_feed, hash_valid, busy;
    logic [511:0] core_message;
    logic [159:0] core_hash, hash;
    logic         core_done = 1'b1;
    logic [159:0] core_h = H0;
    logic [511:0] core_blk = '0;
    int           core_cnt = 0;
    logic         long_mode = 1'b0;

    chk_t         chk_q[$];
    logic [511:0] exp_blk[$];
    logic [159:0] exp_hash[$];
    int           errors = 0;
    int           checks = 0;
    int           blocks_seen = 0;
    logic [511:0] last_blk = '0;
    bit           drop_pend = 1'b0;

    always #5 clk = ~clk;

    sha1_block_feeder_if bus ();

    sha1_block_feeder #(.LEN_W(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_if        (bus),
        .core_init    (core_init),
        .core_feed    (core_feed),
        .core_message (core_message),
        .core_done    (core_done),
        .core_hash    (core_hash),
        .hash         (hash),
        .hash_valid   (hash_valid),
        .busy         (busy)
    );

    function automatic logic [159:0] sha1_compress(input logic [159:0] h, input logic [511:0] m);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, t;
        for (int i = 0; i < 16; i++) w[i] = m[511-32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {t[30:0], t[31]};
        end
        {a, b, c, d, e} = h;
        for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
            else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
            else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
            else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
            t = {a[26:0], a[31:27]} + f + e + k + w[i];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
        end
        return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
    endfunction

    // Behavioural core: done drops after acceptance, rises when compression finishes.
    assign core_hash = core_h;
    always @(posedge clk) begin
        if (core_init) core_h <= H0;
        if (core_done && core_feed) begin
            core_blk  <= core_message;
            core_done <= 1'b0;
            core_cnt  <= long_mode ? 80 : int'($urandom_range(1, 6));
        end else if (!core_done) begin
            if (core_cnt <= 1) begin
                core_h    <= sha1_compress(core_h, core_blk);
                core_done <= 1'b1;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: drains posted checks and scores every block handoff and digest.
    initial forever begin
        @(negedge clk);
        while (chk_q.size() > 0) begin
            chk_t c;
            c = chk_q.pop_front();
            check(c.name, c.act, c.exp);
        end
        if (reset_n) begin
            if (drop_pend) check("feed_drop", 512'(core_feed), 512'(0));
            drop_pend = 1'b0;
            if (core_feed && core_done) begin
                blocks_seen++;
                last_blk  = core_message;
                drop_pend = 1'b1;
                if (exp_blk.size() == 0) check("unexpected_block", 512'(1), 512'(0));
                else check("block", core_message, exp_blk.pop_front());
            end
            if (hash_valid) begin
                if (exp_hash.size() == 0) check("unexpected_hash", 512'(1), 512'(0));
                else check("digest", 512'(hash), 512'(exp_hash.pop_front()));
                check("busy_at_hash", 512'(busy), 512'(0));
            end
        end else begin
            drop_pend = 1'b0;
        end
    end

    task automatic post(input string name, input logic [511:0] act, input logic [511:0] exp);
        chk_t c;
        c.name = name; c.act = act; c.exp = exp;
        chk_q.push_back(c);
    endtask

    // Reference: RFC-3174 padding on a byte queue, then chained compression.
    task automatic model_msg(input bq_t m, output int nblk);
        bq_t          p;
        logic [63:0]  bl;
        logic [511:0] blk;
        logic [159:0] h;
        p = m;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(m.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        h = H0;
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b+j];
            exp_blk.push_back(blk);
            h = sha1_compress(h, blk);
        end
        exp_hash.push_back(h);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input int gap_pct, output bit ok);
        while (int'($urandom_range(0, 99)) < gap_pct) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            bus.in_last  = 1'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        ok = 1'b0;
        for (int n = 0; n < 2000 && !ok; n++) begin
            if (bus.in_ready) ok = 1'b1;
            @(negedge clk);
        end
        if (!ok) post("byte_accept_timeout", 512'(0), 512'(1));
    endtask

    task automatic drive_msg(input bq_t m, input int gap_pct);
        int nblk, base, n;
        bit ok;
        model_msg(m, nblk);
        base = blocks_seen;
        foreach (m[i]) begin
            send_byte(m[i], 1'(i == m.size() - 1), gap_pct, ok);
            if (!ok) break;
            if (i == 0) post("busy_after_first", 512'(busy), 512'(1));
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        n = 0;
        while (exp_hash.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        post("hash_pending", 512'(exp_hash.size()), 512'(0));
        post("block_count", 512'(blocks_seen - base), 512'(nblk));
    endtask

    task automatic mk_str(input string s, output bq_t q);
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
    endtask

    task automatic mk_fill(input int len, input logic [7:0] v, output bq_t q);
        q = {};
        for (int i = 0; i < len; i++) q.push_back(v);
    endtask

    initial begin
        bq_t          m;
        bit           ok;
        logic [511:0] blk_c;
        int           lens[13] = '{1, 54, 55, 56, 57, 63, 64, 65, 119, 120, 127, 128, 0};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        repeat (3) @(negedge clk);
        post("rst_in_ready", 512'(bus.in_ready), 512'(0));
        post("rst_core_init", 512'(core_init), 512'(0));
        post("rst_core_feed", 512'(core_feed), 512'(0));
        post("rst_core_message", core_message, 512'(0));
        post("rst_hash", 512'(hash), 512'(0));
        post("rst_hash_valid", 512'(hash_valid), 512'(0));
        post("rst_busy", 512'(busy), 512'(0));
        reset_n = 1'b1;
        @(negedge clk);
        post("idle_in_ready", 512'(bus.in_ready), 512'(1));

        mk_str("abc", m);
        drive_msg(m, 0);
        post("abc_digest", 512'(hash), 512'(160'ha9993e364706816aba3e25717850c26c9cd0d89d));
        blk_c = {24'h616263, 8'h80, 416'h0, 64'h18};
        post("abc_block", last_blk, blk_c);

        mk_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", m);
        drive_msg(m, 0);
        post("abc56_digest", 512'(hash), 512'(160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1));
        blk_c = {448'h0, 64'h1c0};
        post("abc56_last_block", last_blk, blk_c);

        mk_fill(55, 8'h61, m);
        drive_msg(m, 0);
        blk_c = {{55{8'h61}}, 8'h80, 64'h1b8};
        post("a55_block", last_blk, blk_c);

        mk_fill(64, 8'h61, m);
        drive_msg(m, 0);
        blk_c = {8'h80, 440'h0, 64'h200};
        post("a64_last_block", last_blk, blk_c);

        long_mode = 1'b1;
        mk_str("abc", m);
        drive_msg(m, 40);
        post("abc_slow_digest", 512'(hash), 512'(160'ha9993e364706816aba3e25717850c26c9cd0d89d));
        mk_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", m);
        drive_msg(m, 30);
        post("abc56_slow_digest", 512'(hash), 512'(160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1));
        long_mode = 1'b0;

        // Abort "abc" after two bytes, then resend it whole.
        send_byte(8'h61, 1'b0, 0, ok);
        send_byte(8'h62, 1'b0, 0, ok);
        bus.in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        post("midrst_busy", 512'(busy), 512'(0));
        post("midrst_hash", 512'(hash), 512'(0));
        post("midrst_in_ready", 512'(bus.in_ready), 512'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        mk_str("abc", m);
        drive_msg(m, 0);
        post("abc_after_rst_digest", 512'(hash), 512'(160'ha9993e364706816aba3e25717850c26c9cd0d89d));

        lens[12] = int'($urandom_range(2, 200));
        foreach (lens[i]) begin
            m = {};
            for (int j = 0; j < lens[i]; j++) m.push_back(8'($urandom));
            long_mode = 1'($urandom_range(0, 3) == 0);
            drive_msg(m, int'($urandom_range(0, 40)));
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha1_block_feeder.md
Name: sha1_block_feeder

Overview:
- Producer-side front end for the SHA1 compression core.
- Accepts a byte stream with valid/ready handshake and assembles big-endian 512-bit blocks.
- Appends RFC-3174 padding (0x80, zero fill, 64-bit bit-length) and drives the core's init/feed/done interface one block at a time.
- Reports the final 160-bit digest once per message; sits between the HMAC/OTP message builder and the SHA1 core.

Parameters:
- LEN_W, 32, width of the internal byte counter; max message = 2^LEN_W-1 bytes; the bit length placed in the pad is zero-extended to 64 bits.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_data/in_last valid
- in_ready  out  1  feeder accepts a byte this cycle
- in_data  in  8  message byte, first byte first
- in_last  in  1  marks final byte of the message (messages are >=1 byte)
- core_init  out  1  one-cycle pulse, wired to the core's active-high synchronous reset; reloads the initial hash value
- core_feed  out  1  block on core_message valid
- core_message  out  512  block; byte 0 at [511:504]
- core_done  in  1  core idle/ready; the core takes a block when core_done && core_feed
- core_hash  in  160  core running hash
- hash  out  160  digest of the last completed message, held until the next hash_valid
- hash_valid  out  1  one-cycle pulse when hash updates
- busy  out  1  high from the first accepted byte until hash_valid

Behaviour:
- Reset (async, reset_n low) values:
  - state=IDLE; in_ready=0; core_init=0; core_feed=0; core_message=0.
  - hash=0; hash_valid=0; busy=0; byte counter=0.
- States: IDLE, INIT, FILL, PAD, FEED, WAIT, EXTRA, OUT.
- IDLE: in_ready=1. The first accepted byte goes to INIT.
  - The byte is written at offset 0, count=1.
  - core_init pulses in that same cycle as a registered output, so it is high during the INIT cycle.
- INIT: one cycle; in_ready=0; go to FILL, or to PAD if that first byte had in_last.
- FILL: in_ready=1; one byte per cycle; offset = count[5:0]; count increments.
  - Byte 64 of a block (offset 63) without in_last: go to FEED with the pending-more flag set.
  - in_last: go to PAD.
- PAD: single cycle, in_ready=0. Let k = offset after the last byte (0..63, where 0 means the block just filled).
  - k=0: the block is already full; it goes to FEED, and a fresh block of 0x80, zeros and length follows as EXTRA.
  - k<=55: byte k=0x80, bytes k+1..55=0, bytes 56..63 = count*8 as a big-endian 64-bit value; one final block.
  - k>=56: byte k=0x80, remaining bytes=0; FEED, then EXTRA (zeros 0..55 + length).
- FEED: core_feed=1, core_message stable.
  - On the cycle core_done && core_feed, deassert core_feed in the next cycle and go to WAIT.
- WAIT: first wait for core_done=0, then core_done=1 (the core drops done the cycle after acceptance).
  - Then go to FILL (clearing the block), or EXTRA if a pad block is pending, or OUT if this was the final block.
  - Buffer clearing: a new block's unused bytes must read 0 before padding.
- EXTRA: build the padding-only block (0x80 only if k=0, length at 56..63) in one cycle, then FEED.
- OUT: hash<=core_hash; hash_valid=1 for one cycle; busy=0; go to IDLE.
- in_ready is 0 in INIT, PAD, FEED, WAIT, EXTRA and OUT. No byte is lost or duplicated under any in_valid pattern.
- Byte counter wraps silently at 2^LEN_W. Overflow is a caller error; there is no detection.
- reset_n asserted mid-message: everything returns to reset values immediately. The core is re-initialised by the next message's core_init.
- core_done stuck high in WAIT never advances the FSM on its own; the low-then-high sequence is mandatory.

Decomposition:
- Package sha1_pkg: SHA1 block width (512) and digest width (160); the feeder state enum; the pad byte constant 8'h80; the length field offset (56).
- One sub-module, sha1_pad_block: combinational; inputs are the current block, k, the extra/final flag and the bit length; output is the padded 512-bit block. Used in both PAD and EXTRA.

Test Plan:
- "abc" (3 bytes, in_valid held high) -> one core_feed block = 61626380 00...00 00000018; hash = a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d.
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> two blocks, second = 00...00 000001c0; hash = 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1.
- 55 bytes of 0x61 -> exactly one block with 0x80 at byte 55 and length 0x1b8.
- 64 bytes of 0x61 -> two blocks, second = 80 00..00 00000200.
- Random in_valid gaps plus a core model holding core_done low for 80 cycles -> same digests, and feed is never asserted twice per block.
- reset_n pulse during FILL of "abc", then resend "abc" -> busy=0 and hash=0 immediately after the reset, then the correct "abc" digest.
